rx_cic: RTL and testbench
=========================

# rx_cic

Variable-rate CIC decimator for the receive path. Takes 14-bit signed ADC samples at the converter rate, decimates by a runtime-selectable factor of 4..4095, and delivers left-justified 16-bit signed samples on a streaming source interface with valid/ready backpressure. It is the receive-side counterpart of the TX CIC interpolator and sits between the ADC capture register and the downstream channel filter/FIFO.

## Interface
- IN_W, 14, input sample width (signed)
- OUT_W, 16, output sample width (signed)
- N, 5, number of integrator/comb stages (differential delay M=1)
- RATE_W, 12, width of rate port; accumulator width W = IN_W + N*RATE_W (74 at defaults)

- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high; clears all state
- clken  in  1  sample strobe; input is accepted only when clken && in_valid
- in_valid  in  1  in_data valid
- in_data  in  IN_W  signed ADC sample
- in_ovr  in  1  ADC over-range flag, qualified with in_valid
- rate  in  RATE_W  decimation factor R; values <4 treated as 4
- out_valid  out  1  out_data holds an undelivered sample
- out_ready  in  1  sink accepts when out_valid && out_ready
- out_data  out  OUT_W  decimated sample
- out_error  out  2  bit0 = one or more samples dropped before this one; bit1 = ADC over-range within this sample's window

## Operation
- Accept = clken && in_valid. Integrators (N stages, W bits, two's-complement wrap) update only on accept.
- Decimation counter 0..R-1 advances on accept; on accept with count==R-1 it wraps to 0 and raises strobe.
- Rate is latched (R_eff = max(rate,4), L = clog2(R_eff)) only on reset or counter wrap. If latched value differs from previous: integrators, combs, counter cleared, discard counter loaded with N.
- On strobe: last integrator output enters N-stage comb pipeline (one stage per clock, per-stage valid bit, W bits wrap).
- Scaling: comb result bits [IN_W-1+N*L : IN_W-OUT_W+N*L] form out_data (truncation). Gain ≤ 2^(N*L), so no saturation needed.
- Discard counter nonzero: comb result dropped, counter decremented; out register untouched.
- Output register single-entry. Loaded when empty or being read in the same cycle. If full and not read: new sample dropped, drop-sticky set; sticky copied into out_error[0] of next loaded sample then cleared.
- in_ovr OR-accumulated over decimation window; copied to out_error[1] with that window's sample.

## Timing
- Reset values: out_valid=0, out_data=0, out_error=0; all integrators, combs, counters, stickies 0; discard counter = N; R_eff latched from rate.
- Accept at edge t updates integrators; strobe registered at t+1; comb stage k result at t+1+k; out_valid high after edge t+N+2 (latency N+2 clocks from the completing accept).
- out_valid holds, with data/error stable, until out_ready sampled high; falls next edge unless reloaded in that same cycle.
- Back-to-back accepts every cycle supported; strobes ≥4 cycles apart, so comb pipeline never collides.
- Reset mid-operation: in-flight comb samples and pending output lost; first delivered sample after reset is the (N+1)th decimated output.
- clken low: no state change in integrators/counter; comb pipeline and output handshake continue.

## Test plan
- DC: rate=8, in_data=1000 every cycle from reset -> first delivered out_data=4000, all following 4000, out_error=0, one out_valid per 8 accepts.
- Non-power-of-2: rate=5, in_data=8191 constant -> steady out_data=3124; in_data=-8192 -> steady -3125.
- Rate change: rate 8->16 mid-stream with DC 1000 -> switch at counter wrap, next N outputs suppressed, then 4000 continues; no transient value ever delivered.
- Backpressure: rate=4, out_ready low for 12 accepts -> first sample held stable, two later samples dropped; next delivered sample after out_ready rises has out_error[0]=1, following has 0.
- Over-range/clken: in_ovr pulsed once in window 3, clken low 50% -> only window 3 sample has out_error[1]=1; output rate follows accepted count, not clock count.
- Reset: assert reset for 1 cycle while out_valid=1 and combs busy -> out_valid=0 next edge, out_data=0; recovery as in DC test.

Source files
------------

// File: rtl/rx_cic.sv
// rx_cic: variable-rate CIC decimator (N integrators, N combs, M=1) feeding a
// single-entry valid/ready output register with drop and over-range flags.
module rx_cic #(
  parameter int IN_W   = 14,
  parameter int OUT_W  = 16,
  parameter int N      = 5,
  parameter int RATE_W = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_ovr,
  input  logic [RATE_W-1:0]       rate,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [1:0]              out_error
);

  localparam int W  = IN_W + N * RATE_W;
  localparam int DW = $clog2(N + 1);
  localparam int LW = $clog2(RATE_W + 1);
  localparam int SW = $clog2(W);

  function automatic logic [RATE_W-1:0] eff_rate(input logic [RATE_W-1:0] r);
    return (r < RATE_W'(4)) ? RATE_W'(4) : r;
  endfunction

  function automatic logic [LW-1:0] ceil_log2(input logic [RATE_W-1:0] r);
    logic [RATE_W-1:0] m;
    logic [LW-1:0]     l;
    m = r - 1'b1;
    l = '0;
    for (int i = 0; i < RATE_W; i++)
      if (m[i]) l = LW'(i + 1);
    return l;
  endfunction

  logic [RATE_W-1:0]       rate_reg;
  logic [RATE_W-1:0]       rate_new;
  logic [RATE_W-1:0]       cnt_reg;
  logic [LW-1:0]           l_reg;
  logic signed [W-1:0]     integ_reg  [N];
  logic signed [W-1:0]     integ_next [N];
  logic signed [W-1:0]     stg_data   [N+1];
  logic signed [W-1:0]     comb_dly   [N];
  logic signed [W-1:0]     comb_diff  [N];
  logic [N:0]              stg_vld;
  logic [N:0]              stg_ovr;
  logic                    strobe_reg;
  logic                    strobe_ovr_reg;
  logic                    ovr_acc_reg;
  logic                    drop_reg;
  logic [DW-1:0]           discard_reg;
  logic                    accept;
  logic                    wrap;
  logic                    rate_change;
  logic [SW-1:0]           shift_amt;
  logic signed [OUT_W-1:0] scaled;

  assign accept      = clken & in_valid;
  assign wrap        = accept && (cnt_reg == rate_reg - 1'b1);
  assign rate_new    = eff_rate(rate);
  assign rate_change = wrap && (rate_new != rate_reg);

  // Take the OUT_W bits just below the top of the N*L-bit gain.
  assign shift_amt = SW'(N * l_reg - (OUT_W - IN_W));
  assign scaled    = OUT_W'(stg_data[N] >>> shift_amt);

  always_comb begin
    integ_next[0] = integ_reg[0] + W'(in_data);
    for (int k = 1; k < N; k++)
      integ_next[k] = integ_reg[k] + integ_next[k-1];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_comb
    assign comb_diff[gi] = stg_data[gi] - comb_dly[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rate_reg <= rate_new;
      l_reg    <= ceil_log2(rate_new);
      cnt_reg  <= '0;
      for (int k = 0; k < N; k++) begin
        integ_reg[k] <= '0;
        comb_dly[k]  <= '0;
      end
      for (int k = 0; k <= N; k++) stg_data[k] <= '0;
      stg_vld        <= '0;
      stg_ovr        <= '0;
      strobe_reg     <= 1'b0;
      strobe_ovr_reg <= 1'b0;
      ovr_acc_reg    <= 1'b0;
      drop_reg       <= 1'b0;
      discard_reg    <= DW'(N);
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_error      <= '0;
    end else begin
      strobe_reg <= 1'b0;
      if (accept) begin
        for (int k = 0; k < N; k++) integ_reg[k] <= integ_next[k];
        if (wrap) begin
          cnt_reg     <= '0;
          ovr_acc_reg <= 1'b0;
          rate_reg    <= rate_new;
          l_reg       <= ceil_log2(rate_new);
          if (!rate_change) begin
            strobe_reg     <= 1'b1;
            strobe_ovr_reg <= ovr_acc_reg | in_ovr;
          end
        end else begin
          cnt_reg     <= cnt_reg + 1'b1;
          ovr_acc_reg <= ovr_acc_reg | in_ovr;
        end
      end

      // Capture the last integrator one clock after the strobe, then comb.
      stg_vld[0] <= strobe_reg;
      if (strobe_reg) begin
        stg_data[0] <= integ_reg[N-1];
        stg_ovr[0]  <= strobe_ovr_reg;
      end
      for (int k = 1; k <= N; k++) begin
        stg_vld[k] <= stg_vld[k-1];
        if (stg_vld[k-1]) begin
          stg_data[k]   <= comb_diff[k-1];
          stg_ovr[k]    <= stg_ovr[k-1];
          comb_dly[k-1] <= stg_data[k-1];
        end
      end

      if (out_valid && out_ready) out_valid <= 1'b0;
      if (stg_vld[N]) begin
        if (discard_reg != '0) begin
          discard_reg <= discard_reg - 1'b1;
        end else if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_data  <= scaled;
          out_error <= {stg_ovr[N], drop_reg};
          drop_reg  <= 1'b0;
        end else begin
          drop_reg <= 1'b1;
        end
      end

      // A new rate restarts the filter from zero; its first N outputs are transients.
      if (rate_change) begin
        for (int k = 0; k < N; k++) begin
          integ_reg[k] <= '0;
          comb_dly[k]  <= '0;
        end
        for (int k = 0; k <= N; k++) stg_data[k] <= '0;
        stg_vld     <= '0;
        strobe_reg  <= 1'b0;
        discard_reg <= DW'(N);
      end
    end
  end

endmodule

// File: tb/tb_rx_cic.sv
// Self-checking bench for rx_cic: a reference model predicts each delivered
// sample (DC gain R^N, truncation, flags) and a monitor pops/compares on handshake.
module tb_rx_cic;
  localparam int IN_W = 14, OUT_W = 16, N = 5, RATE_W = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clken = 1'b0, in_valid = 1'b0, in_ovr = 1'b0, out_ready = 1'b1;
  logic signed [IN_W-1:0]  in_data = '0;
  logic [RATE_W-1:0]       rate = 12'd8;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic [1:0]              out_error;

  rx_cic #(.IN_W(IN_W), .OUT_W(OUT_W), .N(N), .RATE_W(RATE_W)) dut (
    .clk(clk), .reset(reset), .clken(clken), .in_valid(in_valid),
    .in_data(in_data), .in_ovr(in_ovr), .rate(rate), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_error(out_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  logic [17:0] exp_q [$];
  int m_rate, m_cnt, m_disc, m_win, skip_lo, skip_hi;
  logic m_ovr, m_drop;
  int first_acc_edge, first_rise_edge;

  function automatic int eff(input int r);
    return (r < 4) ? 4 : r;
  endfunction

  function automatic int clog2_i(input int r);
    int l = 0;
    while ((1 << l) < r) l++;
    return l;
  endfunction

  // Steady DC response: x * R^N, scaled down by 2^(N*L - (OUT_W-IN_W)), floored.
  function automatic logic [15:0] exp_dc(input int x, input int r);
    longint p = x;
    int sh;
    repeat (N) p = p * r;
    sh = N * clog2_i(r) - (OUT_W - IN_W);
    p = p >>> sh;
    return p[15:0];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_rate = eff(int'(rate));
    m_cnt = 0; m_disc = N; m_win = 0; m_ovr = 1'b0; m_drop = 1'b0;
    skip_lo = 0; skip_hi = -1;
    first_acc_edge = 0; first_rise_edge = 0;
  endtask

  task automatic drive_accept(input int x, input logic ovr, input logic rdy);
    @(posedge clk); #1;
    clken = 1'b1; in_valid = 1'b1; in_data = 14'(x); in_ovr = ovr; out_ready = rdy;
    m_ovr = m_ovr | ovr;
    if (m_cnt == m_rate - 1) begin
      m_cnt = 0;
      if (eff(int'(rate)) != m_rate) begin
        m_rate = eff(int'(rate));
        m_disc = N;
      end else if (m_disc > 0) begin
        m_disc--;
      end else begin
        m_win++;
        if (m_win == 1) first_acc_edge = cyc + 1;
        if (m_win >= skip_lo && m_win <= skip_hi) m_drop = 1'b1;
        else begin
          exp_q.push_back({exp_dc(x, m_rate), m_ovr, m_drop});
          m_drop = 1'b0;
        end
      end
      m_ovr = 1'b0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic idle_cycle(input int junk);
    @(posedge clk); #1;
    clken = 1'b0; in_valid = 1'b1; in_data = 14'(junk); in_ovr = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1; clken = 1'b0; in_valid = 1'b0; in_ovr = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drain(input string name);
    @(posedge clk); #1;
    clken = 1'b0; in_valid = 1'b0; in_ovr = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (12) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: outstanding=%0d, required 0", name, exp_q.size());
    end
  endtask

  // Output monitor: scoreboard pop on handshake, stability while stalled.
  logic        hold_active = 1'b0, prev_valid = 1'b0;
  logic [17:0] held, mon_e;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_active = 1'b0;
        prev_valid  = 1'b0;
      end else begin
        if (hold_active) begin
          checks++;
          if (out_valid !== 1'b1 || {out_data, out_error} !== held) begin
            errors++;
            $display("FAIL hold: got valid=%b data=%0d err=%b, required valid=1 data=%0d err=%b",
                     out_valid, out_data, out_error, $signed(held[17:2]), held[1:0]);
          end
        end
        if (out_valid && !prev_valid && first_rise_edge == 0) first_rise_edge = cyc;
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got data=%0d err=%b, required no output",
                     out_data, out_error);
          end else begin
            mon_e = exp_q.pop_front();
            $display("out data=%0d err=%b", out_data, out_error);
            if ({out_data, out_error} !== mon_e) begin
              errors++;
              $display("FAIL sample: got data=%0d err=%b, required data=%0d err=%b",
                       out_data, out_error, $signed(mon_e[17:2]), mon_e[1:0]);
            end
          end
        end
        hold_active = out_valid && !out_ready;
        held        = {out_data, out_error};
        prev_valid  = out_valid;
      end
    end
  end

  task automatic test_reset();
    rate = 12'd8;
    apply_reset();
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    if (out_data !== 16'sd0) begin errors++; $display("FAIL reset_data: got %0d, required 0", out_data); end
    if (out_error !== 2'b00) begin errors++; $display("FAIL reset_error: got %b, required 00", out_error); end
  endtask

  task automatic test_dc();
    rate = 12'd8;
    apply_reset();
    for (int k = 0; k < 12 * 8; k++) drive_accept(1000, 1'b0, 1'b1);
    drain("dc");
    checks++;
    if (first_rise_edge - first_acc_edge != N + 2) begin
      errors++;
      $display("FAIL dc_latency: got %0d clocks, required %0d", first_rise_edge - first_acc_edge, N + 2);
    end
  endtask

  task automatic test_non_pow2();
    rate = 12'd5;
    apply_reset();
    for (int k = 0; k < 10 * 5; k++) drive_accept(8191, 1'b0, 1'b1);
    drain("pos_fs");
    apply_reset();
    for (int k = 0; k < 10 * 5; k++) drive_accept(-8192, 1'b0, 1'b1);
    drain("neg_fs");
  endtask

  task automatic test_rate_change();
    rate = 12'd8;
    apply_reset();
    for (int k = 0; k < 100; k++) drive_accept(1000, 1'b0, 1'b1);
    rate = 12'd16;
    for (int k = 0; k < 180; k++) drive_accept(1000, 1'b0, 1'b1);
    drain("rate_change");
  endtask

  task automatic test_backpressure();
    rate = 12'd4;
    apply_reset();
    skip_lo = 2; skip_hi = 3;
    for (int k = 1; k <= 60; k++) drive_accept(1000, 1'b0, !(k >= 28 && k <= 39));
    drain("backpressure");
  endtask

  task automatic test_ovr_clken();
    rate = 12'd2;
    apply_reset();
    for (int k = 1; k <= 48; k++) begin
      drive_accept(500, k == 30, 1'b1);
      idle_cycle(7777);
    end
    drain("ovr_clken");
  endtask

  task automatic test_reset_mid();
    int k;
    rate = 12'd8;
    apply_reset();
    k = 0;
    while (out_valid !== 1'b1 && k < 120) begin
      drive_accept(1000, 1'b0, 1'b0);
      k++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_wait: got valid=%b after %0d accepts, required 1", out_valid, k);
    end
    repeat (3) drive_accept(1000, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; clken = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    model_reset();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid: got %b, required 0", out_valid); end
    if (out_data !== 16'sd0) begin errors++; $display("FAIL reset_mid_data: got %0d, required 0", out_data); end
    for (int j = 0; j < 12 * 8; j++) drive_accept(1000, 1'b0, 1'b1);
    drain("reset_recovery");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_dc();
    test_non_pow2();
    test_rate_change();
    test_backpressure();
    test_ovr_clken();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
